// File: rtl/pipe_stage_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg_pkg : state encodings and stage payload layout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_stage_reg_pkg;

   localparam logic [1:0] PS_EMPTY   = 2'd0;
   localparam logic [1:0] PS_FULL    = 2'd1;
   localparam logic [1:0] PS_SKIDDED = 2'd2;

   // MEM/WB payload: {rf_we, wR[4:0], wD[31:0], debug_pc[31:0]}
   localparam int MEMWB_PC = 0;
   localparam int MEMWB_WD = 32;
   localparam int MEMWB_WR = 64;
   localparam int MEMWB_WE = 69;
   localparam int MEMWB_DW = 70;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [31:0] debug_pc;
   } memwb_payload_t;

   function automatic logic ps_is_live(input logic [1:0] state);
      return state != PS_EMPTY;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg : inter-stage register with valid/ready, flush, optional skid
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int            DW      = 32,
   parameter logic [DW-1:0] RST_VAL = '0,
   parameter bit            SKID    = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o
);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [DW-1:0] r_main;
   logic [DW-1:0] w_skid;
   logic          w_in_ready;
   logic          w_accept;
   logic          w_emit;
   logic          w_load_in;
   logic          w_load_skid;
   logic          w_load_from_skid;

   assign w_accept    = in_valid_i & w_in_ready;
   assign w_emit      = out_valid_o & out_ready_i;
   assign out_valid_o = ps_is_live(r_state);
   assign out_data_o  = r_main;
   assign in_ready_o  = w_in_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_in        = 1'b0;
      w_load_skid      = 1'b0;
      w_load_from_skid = 1'b0;
      if (flush_i) begin
         w_state_nxt = PS_EMPTY;
      end else begin
         case (r_state)
            PS_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = PS_FULL;
                  w_load_in   = 1'b1;
               end
            end
            PS_FULL: begin
               if (w_accept && w_emit) begin
                  w_load_in = 1'b1;
               end else if (w_accept && SKID) begin
                  w_state_nxt = PS_SKIDDED;
                  w_load_skid = 1'b1;
               end else if (w_emit) begin
                  w_state_nxt = PS_EMPTY;
               end
            end
            PS_SKIDDED: begin
               if (w_emit) begin
                  w_state_nxt      = PS_FULL;
                  w_load_from_skid = 1'b1;
               end
            end
            default: w_state_nxt = PS_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PS_EMPTY;
         r_main  <= RST_VAL;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_in) begin
            r_main <= in_data_i;
         end else if (w_load_from_skid) begin
            r_main <= w_skid;
         end
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [DW-1:0] r_skid;
         logic          r_in_ready;

         // Ready is flopped from the next state so it never depends on out_ready_i.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_skid     <= RST_VAL;
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= (w_state_nxt != PS_SKIDDED);
               if (w_load_skid) begin
                  r_skid <= in_data_i;
               end
            end
         end

         assign w_skid     = r_skid;
         assign w_in_ready = r_in_ready;
      end else begin : g_noskid
         assign w_skid     = RST_VAL;
         assign w_in_ready = ~out_valid_o | out_ready_i;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: SKID=1 vector table with scoreboard, plus SKID=0 and reset corners.
`default_nettype none

module tb_pipe_stage_reg;

   localparam int         DW   = 8;
   localparam logic [7:0] RSTV = 8'h5A;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, iv, ir, ov, ordy;
   logic [7:0] idata, odata;
   logic       iv0, ir0, ov0, ordy0;
   logic [7:0] idata0, odata0;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sb[$];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DW(DW), .RST_VAL(RSTV), .SKID(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .in_valid_i(iv), .in_ready_o(ir), .in_data_i(idata),
      .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(odata)
   );

   pipe_stage_reg #(.DW(DW), .RST_VAL(RSTV), .SKID(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
      .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(idata0),
      .out_valid_o(ov0), .out_ready_i(ordy0), .out_data_o(odata0)
   );

   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      logic       exp_ov;
      logic       exp_ir;
      logic [7:0] exp_od;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setv(input int i, input logic v, input logic [7:0] d, input logic r,
                       input logic f, input logic eov, input logic eir, input logic [7:0] eod);
      vecs[i].iv = v;   vecs[i].d = d;       vecs[i].ordy = r;  vecs[i].fl = f;
      vecs[i].exp_ov = eov; vecs[i].exp_ir = eir; vecs[i].exp_od = eod;
   endtask

   initial begin
      //      iv  data   rdy  fl   ov   ir   od (checked only when ov)
      setv(0,  1, 8'h11, 1, 0,   0, 1, 8'h00);
      setv(1,  1, 8'h22, 1, 0,   1, 1, 8'h11);
      setv(2,  1, 8'h33, 1, 0,   1, 1, 8'h22);
      setv(3,  0, 8'h00, 1, 0,   1, 1, 8'h33);
      setv(4,  1, 8'hA1, 0, 0,   0, 1, 8'h00);
      setv(5,  1, 8'hA2, 0, 0,   1, 1, 8'hA1);
      setv(6,  1, 8'hA3, 0, 0,   1, 0, 8'hA1);
      setv(7,  0, 8'h00, 1, 0,   1, 0, 8'hA1);
      setv(8,  0, 8'h00, 1, 0,   1, 1, 8'hA2);
      setv(9,  1, 8'hC1, 0, 0,   0, 1, 8'h00);
      setv(10, 1, 8'hC2, 0, 0,   1, 1, 8'hC1);
      setv(11, 1, 8'hB0, 0, 1,   1, 0, 8'hC1);
      setv(12, 1, 8'hD1, 0, 0,   0, 1, 8'h00);
      setv(13, 1, 8'hB1, 0, 1,   1, 1, 8'hD1);
      setv(14, 0, 8'h00, 1, 0,   0, 1, 8'h00);
      setv(15, 1, 8'hE1, 1, 0,   0, 1, 8'h00);
      setv(16, 0, 8'h00, 1, 0,   1, 1, 8'hE1);
      setv(17, 0, 8'h00, 1, 0,   0, 1, 8'h00);

      rst_n = 1'b0; flush = 1'b0; iv = 1'b1; idata = 8'hFF; ordy = 1'b1;
      iv0 = 1'b0; idata0 = 8'h00; ordy0 = 1'b1;

      // Reset held across edges with valid asserted upstream
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", ov, 0);
      check("rst_out_data", odata, RSTV);
      check("rst_in_ready", ir, 1);

      @(negedge clk);
      rst_n = 1'b1;
      iv = 1'b0;

      for (int i = 0; i < 18; i++) begin
         logic acc, emi;
         @(negedge clk);
         iv = vecs[i].iv; idata = vecs[i].d; ordy = vecs[i].ordy; flush = vecs[i].fl;
         #1;
         check($sformatf("v%0d_out_valid", i), ov, vecs[i].exp_ov);
         check($sformatf("v%0d_in_ready", i), ir, vecs[i].exp_ir);
         if (vecs[i].exp_ov)
            check($sformatf("v%0d_out_data", i), odata, vecs[i].exp_od);
         acc = iv & ir;
         emi = ov & ordy;
         if (emi) begin
            if (sb.size() == 0) begin
               check($sformatf("v%0d_sb_underflow", i), 1, 0);
            end else begin
               check($sformatf("v%0d_sb_data", i), odata, sb.pop_front());
            end
         end
         if (flush) sb.delete();
         else if (acc) sb.push_back(idata);
      end
      @(negedge clk);
      iv = 1'b0; flush = 1'b0;
      check("sb_empty", sb.size(), 0);

      // Async reset while SKIDDED: outputs must drop before any clock edge
      ordy = 1'b0; iv = 1'b1; idata = 8'h61;
      @(negedge clk); idata = 8'h62;
      @(negedge clk); iv = 1'b0;
      #1;
      check("pre_rst_in_ready", ir, 0);
      check("pre_rst_out_valid", ov, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", ov, 0);
      check("arst_in_ready", ir, 1);
      check("arst_out_data", odata, RSTV);

      // First accept on the first posedge after release
      @(negedge clk);
      rst_n = 1'b1; iv = 1'b1; idata = 8'h77;
      @(posedge clk); #1;
      check("post_rst_out_valid", ov, 1);
      check("post_rst_out_data", odata, 8'h77);
      iv = 1'b0; ordy = 1'b1;

      // SKID=0: combinational ready
      @(negedge clk);
      iv0 = 1'b1; idata0 = 8'h44; ordy0 = 1'b0;
      @(posedge clk); #1;
      check("s0_full_valid", ov0, 1);
      check("s0_stall_ready", ir0, 0);
      ordy0 = 1'b1;
      #1;
      check("s0_comb_ready", ir0, 1);
      idata0 = 8'h55;
      @(posedge clk); #1;
      check("s0_pass_data", odata0, 8'h55);
      ordy0 = 1'b0; idata0 = 8'h66;
      #1;
      check("s0_stall_ready2", ir0, 0);
      @(posedge clk); #1;
      check("s0_hold_data", odata0, 8'h55);
      check("s0_hold_valid", ov0, 1);
      iv0 = 1'b0; ordy0 = 1'b1;
      @(posedge clk); #1;
      check("s0_drain_valid", ov0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
